hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised successor to the 5-stage pipeline hazard unit, sitting beside the ID stage. It provides operand forwarding and load-use stall and branch-flush control, as before. It adds a register scoreboard for one variable-latency multi-cycle unit (MUL/DIV) with a completion bypass, WAW and structural stall detection, and optional stall/flush performance counters.

## Interface
- NUM_REGS, 32, architectural registers; x0 never tracked
- ADDR_W, $clog2(NUM_REGS), register address width
- CNT_W, 32, perf counter width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- addr_rs1_ID_i, addr_rs2_ID_i, addr_rd_ID_i  in  ADDR_W  ID source/dest addresses
- reg_write_en_ID_i  in  1  ID instruction writes rd
- mc_req_ID_i  in  1  ID instruction is a multi-cycle op
- addr_rd_EX_i, addr_rd_MEM_i, addr_rd_WB_i  in  ADDR_W  downstream dests
- reg_write_en_EX_i, reg_write_en_MEM_i, reg_write_en_WB_i  in  1  downstream write enables
- sel_wb_EX_i, sel_wb_MEM_i  in  2  writeback select; 2'b00 = memory load
- branch_EX_i  in  1  taken branch/jump redirect in EX
- mc_done_i  in  1  multi-cycle unit result valid (one cycle)
- mc_done_rd_i  in  ADDR_W  destination of completing result
- forward_a_o, forward_b_o  out  3  0 REG, 1 ALU(EX), 2 ALU_MEM, 3 DMEM, 4 WB, 5 MC
- stall_if_o, stall_id_o, flush_id_o, flush_ex_o  out  1  pipeline control
- mc_accept_o  out  1  multi-cycle op leaves ID this cycle
- stall_cycles_o, flush_cycles_o  out  CNT_W  perf counters

## Operation
- State: pending[NUM_REGS-1:0], busy, and perf counters.
- Forward per operand (rs != 0), in priority order:
  - EX match with write enable -> 1.
  - MEM match with write enable: 2 if sel_wb_MEM != 00, else 3.
  - WB match -> 4.
  - mc_done_i & mc_done_rd == rs -> 5.
  - else 0.
- load_stall = sel_wb_EX == 00 & reg_write_en_EX & rd_EX != 0 & (rs1 or rs2 == rd_EX). Zero-register and non-writing loads never stall.
- raw_stall: pending[rs] for either nonzero rs, unless that rs is completing this cycle.
- waw_stall: reg_write_en_ID & rd_ID != 0 & pending[rd_ID] & !(mc_done & mc_done_rd == rd_ID).
- struct_stall = mc_req_ID & busy & !mc_done_i.
- stall = (load_stall | raw_stall | waw_stall | struct_stall) & !branch_EX.
- stall_if_o = stall_id_o = stall.
- flush_id_o = branch_EX.
- flush_ex_o = branch_EX | stall (bubble insertion).
- mc_accept_o = mc_req_ID & !stall & !branch_EX.
- Scoreboard update per edge:
  - Completion clears pending[mc_done_rd]. A completion with rd 0 is ignored for pending.
  - Accept sets pending[rd_ID] when rd_ID != 0. If accept and completion hit the same register, set wins.
  - busy: set on accept, cleared on mc_done without accept. Done and accept in the same cycle leave busy = 1 (back-to-back issue).
- mc_done_i while !busy: pending is cleared as addressed and busy stays 0; no error.

## Timing
- All outputs are combinational from inputs and state, with no latency. Scoreboard effects appear the cycle after the edge.
- A consumer in ID during the mc_done_i cycle proceeds with forward = 5; the following cycle the value comes from WB/REG.
- Reset (asynchronous, any time, including mid multi-cycle op): pending = 0, busy = 0, counters = 0.
  - With quiet inputs, all outputs are 0 immediately and stay 0 until inputs change.
  - A multi-cycle result arriving after reset is ignored.
- branch_EX has priority over all stalls in the same cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles_o increments each cycle stall = 1.
  - flush_cycles_o increments each cycle branch_EX = 1.
  - Both saturate at all-ones and are cleared only by reset.
- Not defined: no counter flops; both outputs are constant 0.

## Test plan
- Load x5 in EX, ID reads rs1 = x5 -> stall_if/stall_id/flush_ex = 1 for 1 cycle. Next cycle the load is in MEM -> forward_a = 3.
- Load with rd = x0 in EX, ID rs1 = x0 -> no stall, forward_a = 0.
- Accept DIV to x7; ID reads x7 for 10 cycles -> stall each cycle. On the mc_done_i, rd = 7 cycle -> stall = 0, forward_a = 5, pending[7] = 0 after the edge.
- busy, new mc_req_ID -> stall. Then mc_done_i for the old op in the same cycle -> mc_accept_o = 1 and busy stays 1.
- Stall pending plus branch_EX = 1 -> stall = 0, flush_id = flush_ex = 1, mc_accept_o = 0. With HAZARD_PERF_EN: flush_cycles = 1, stall_cycles unchanged.
- Assert rst_i mid-DIV with pending[9] set -> pending cleared asynchronously; ID reading x9 no longer stalls; a late mc_done has no effect on busy.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : ID-stage hazard unit: forwarding, load-use/RAW/WAW/structural
//            stalls, branch flush, scoreboard for one multi-cycle unit.
//            Optional perf counters enabled by defining HAZARD_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_rs1_ID_i,
  input  logic [ADDR_W-1:0] addr_rs2_ID_i,
  input  logic [ADDR_W-1:0] addr_rd_ID_i,
  input  logic              reg_write_en_ID_i,
  input  logic              mc_req_ID_i,
  input  logic [ADDR_W-1:0] addr_rd_EX_i,
  input  logic [ADDR_W-1:0] addr_rd_MEM_i,
  input  logic [ADDR_W-1:0] addr_rd_WB_i,
  input  logic              reg_write_en_EX_i,
  input  logic              reg_write_en_MEM_i,
  input  logic              reg_write_en_WB_i,
  input  logic [1:0]        sel_wb_EX_i,
  input  logic [1:0]        sel_wb_MEM_i,
  input  logic              branch_EX_i,
  input  logic              mc_done_i,
  input  logic [ADDR_W-1:0] mc_done_rd_i,
  output logic [2:0]        forward_a_o,
  output logic [2:0]        forward_b_o,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              mc_accept_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_cycles_o
);

  localparam logic [2:0] c_fwd_reg     = 3'd0;
  localparam logic [2:0] c_fwd_ex      = 3'd1;
  localparam logic [2:0] c_fwd_alu_mem = 3'd2;
  localparam logic [2:0] c_fwd_dmem    = 3'd3;
  localparam logic [2:0] c_fwd_wb      = 3'd4;
  localparam logic [2:0] c_fwd_mc      = 3'd5;
  localparam logic [1:0] c_sel_load    = 2'b00;

  logic [NUM_REGS-1:0] r_pending;
  logic                r_busy;

  logic w_load_stall;
  logic w_raw_stall;
  logic w_waw_stall;
  logic w_struct_stall;
  logic w_stall;
  logic w_accept;
  logic w_done_rs1;
  logic w_done_rs2;
  logic w_done_rd;

  // Newest producer wins: EX, then MEM, then WB, then the completing MC result.
  function automatic logic [2:0] fwd_sel(input logic [ADDR_W-1:0] rs);
    fwd_sel = c_fwd_reg;
    if (rs != '0) begin
      if (reg_write_en_EX_i && (addr_rd_EX_i == rs))
        fwd_sel = c_fwd_ex;
      else if (reg_write_en_MEM_i && (addr_rd_MEM_i == rs))
        fwd_sel = (sel_wb_MEM_i != c_sel_load) ? c_fwd_alu_mem : c_fwd_dmem;
      else if (reg_write_en_WB_i && (addr_rd_WB_i == rs))
        fwd_sel = c_fwd_wb;
      else if (mc_done_i && (mc_done_rd_i == rs))
        fwd_sel = c_fwd_mc;
    end
  endfunction

  assign w_done_rs1 = mc_done_i && (mc_done_rd_i == addr_rs1_ID_i);
  assign w_done_rs2 = mc_done_i && (mc_done_rd_i == addr_rs2_ID_i);
  assign w_done_rd  = mc_done_i && (mc_done_rd_i == addr_rd_ID_i);

  assign w_load_stall = (sel_wb_EX_i == c_sel_load) && reg_write_en_EX_i &&
                        (addr_rd_EX_i != '0) &&
                        ((addr_rs1_ID_i == addr_rd_EX_i) || (addr_rs2_ID_i == addr_rd_EX_i));

  // A result completing this cycle is bypassed, so it does not hold the consumer.
  assign w_raw_stall = ((addr_rs1_ID_i != '0) && r_pending[addr_rs1_ID_i] && !w_done_rs1) ||
                       ((addr_rs2_ID_i != '0) && r_pending[addr_rs2_ID_i] && !w_done_rs2);

  assign w_waw_stall = reg_write_en_ID_i && (addr_rd_ID_i != '0) &&
                       r_pending[addr_rd_ID_i] && !w_done_rd;

  assign w_struct_stall = mc_req_ID_i && r_busy && !mc_done_i;

  assign w_stall  = (w_load_stall || w_raw_stall || w_waw_stall || w_struct_stall) &&
                    !branch_EX_i;
  assign w_accept = mc_req_ID_i && !w_stall && !branch_EX_i;

  always_comb begin
    forward_a_o = fwd_sel(addr_rs1_ID_i);
    forward_b_o = fwd_sel(addr_rs2_ID_i);
    stall_if_o  = w_stall;
    stall_id_o  = w_stall;
    flush_id_o  = branch_EX_i;
    flush_ex_o  = branch_EX_i || w_stall;
    mc_accept_o = w_accept;
  end

  // Set is applied after clear so an accept to the completing register wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_busy    <= 1'b0;
    end else begin
      if (mc_done_i && (mc_done_rd_i != '0))
        r_pending[mc_done_rd_i] <= 1'b0;
      if (w_accept && (addr_rd_ID_i != '0))
        r_pending[addr_rd_ID_i] <= 1'b1;
      if (w_accept)
        r_busy <= 1'b1;
      else if (mc_done_i)
        r_busy <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (branch_EX_i && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_cycles_o = r_flush_cnt;
`else
  assign stall_cycles_o = '0;
  assign flush_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic compared against a register-array reference model.
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2, rd_id, rd_ex, rd_mem, rd_wb, mc_done_rd;
  logic          we_id, mc_req, we_ex, we_mem, we_wb, branch, mc_done;
  logic [1:0]    sel_wb_ex, sel_wb_mem;
  logic [2:0]    fwd_a, fwd_b;
  logic          stall_if, stall_id, flush_id, flush_ex, mc_accept;
  logic [CW-1:0] stall_cycles, flush_cycles;

  int checks   = 0;
  int failures = 0;

  bit      m_pending [NREG];
  bit      m_busy;
  longint  m_stall_cnt;
  longint  m_flush_cnt;

  hazard_scoreboard #(.NUM_REGS(NREG), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .addr_rs1_ID_i(rs1), .addr_rs2_ID_i(rs2), .addr_rd_ID_i(rd_id),
    .reg_write_en_ID_i(we_id), .mc_req_ID_i(mc_req),
    .addr_rd_EX_i(rd_ex), .addr_rd_MEM_i(rd_mem), .addr_rd_WB_i(rd_wb),
    .reg_write_en_EX_i(we_ex), .reg_write_en_MEM_i(we_mem), .reg_write_en_WB_i(we_wb),
    .sel_wb_EX_i(sel_wb_ex), .sel_wb_MEM_i(sel_wb_mem),
    .branch_EX_i(branch), .mc_done_i(mc_done), .mc_done_rd_i(mc_done_rd),
    .forward_a_o(fwd_a), .forward_b_o(fwd_b),
    .stall_if_o(stall_if), .stall_id_o(stall_id),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .mc_accept_o(mc_accept),
    .stall_cycles_o(stall_cycles), .flush_cycles_o(flush_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2:0] m_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 3'd0;
    if (we_ex && rd_ex == rs) return 3'd1;
    if (we_mem && rd_mem == rs) return (sel_wb_mem == 2'b00) ? 3'd3 : 3'd2;
    if (we_wb && rd_wb == rs) return 3'd4;
    if (mc_done && mc_done_rd == rs) return 3'd5;
    return 3'd0;
  endfunction

  function automatic bit m_stall();
    bit ld, raw, waw, st;
    ld  = (sel_wb_ex == 2'b00) && we_ex && (rd_ex != 0) && (rs1 == rd_ex || rs2 == rd_ex);
    raw = (rs1 != 0 && m_pending[rs1] && !(mc_done && mc_done_rd == rs1)) ||
          (rs2 != 0 && m_pending[rs2] && !(mc_done && mc_done_rd == rs2));
    waw = we_id && (rd_id != 0) && m_pending[rd_id] && !(mc_done && mc_done_rd == rd_id);
    st  = mc_req && m_busy && !mc_done;
    return (ld || raw || waw || st) && !branch;
  endfunction

  function automatic bit m_accept();
    return mc_req && !m_stall() && !branch;
  endfunction

  function automatic logic [CW-1:0] m_scnt();
`ifdef HAZARD_PERF_EN
    return CW'(m_stall_cnt);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] m_fcnt();
`ifdef HAZARD_PERF_EN
    return CW'(m_flush_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic m_reset();
    foreach (m_pending[i]) m_pending[i] = 1'b0;
    m_busy = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic quiet();
    rs1 = '0; rs2 = '0; rd_id = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
    mc_done_rd = '0; we_id = 0; mc_req = 0; we_ex = 0; we_mem = 0; we_wb = 0;
    branch = 0; mc_done = 0; sel_wb_ex = 2'b01; sel_wb_mem = 2'b01;
  endtask

  // Advance one clock edge and update the model with the inputs held across it.
  task automatic tick();
    bit st, acc;
    st  = m_stall();
    acc = m_accept();
    @(posedge clk);
    if (mc_done && mc_done_rd != 0) m_pending[mc_done_rd] = 1'b0;
    if (acc && rd_id != 0) m_pending[rd_id] = 1'b1;
    if (acc) m_busy = 1'b1;
    else if (mc_done) m_busy = 1'b0;
    if (st) m_stall_cnt++;
    if (branch) m_flush_cnt++;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    quiet();
    rst = 1'b1;
    m_reset();
    #2;
    checks++; if (fwd_a !== 3'd0) begin failures++; $display("FAIL reset fwd_a got %0d exp 0", fwd_a); end
    checks++; if (fwd_b !== 3'd0) begin failures++; $display("FAIL reset fwd_b got %0d exp 0", fwd_b); end
    checks++; if ({stall_if, stall_id, flush_id, flush_ex, mc_accept} !== 5'b0) begin
      failures++; $display("FAIL reset ctrl got %b exp 00000", {stall_if, stall_id, flush_id, flush_ex, mc_accept}); end
    checks++; if (stall_cycles !== '0 || flush_cycles !== '0) begin
      failures++; $display("FAIL reset counters got %0d/%0d exp 0/0", stall_cycles, flush_cycles); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({stall_if, flush_ex, mc_accept, fwd_a} !== 6'b0) begin
      failures++; $display("FAIL reset_release quiet got %b exp 0", {stall_if, flush_ex, mc_accept, fwd_a}); end
  endtask

  task automatic test_load_use();
    quiet();
    rd_ex = 5'd5; we_ex = 1; sel_wb_ex = 2'b00; rs1 = 5'd5;
    #1;
    checks++; if ({stall_if, stall_id, flush_ex, flush_id} !== 4'b1110) begin
      failures++; $display("FAIL load_use ctrl got %b exp 1110", {stall_if, stall_id, flush_ex, flush_id}); end
    tick();
    quiet();
    rd_mem = 5'd5; we_mem = 1; sel_wb_mem = 2'b00; rs1 = 5'd5;
    #1;
    checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL load_use_next stall got %b exp 0", stall_if); end
    checks++; if (fwd_a !== 3'd3) begin failures++; $display("FAIL load_use_next fwd_a got %0d exp 3", fwd_a); end
    tick();
  endtask

  task automatic test_x0_load();
    quiet();
    rd_ex = 5'd0; we_ex = 1; sel_wb_ex = 2'b00; rs1 = 5'd0;
    #1;
    checks++; if (stall_if !== 1'b0 || fwd_a !== 3'd0) begin
      failures++; $display("FAIL x0_load got stall=%b fwd=%0d exp 0/0", stall_if, fwd_a); end
    quiet();
    rd_ex = 5'd6; we_ex = 0; sel_wb_ex = 2'b00; rs2 = 5'd6;
    #1;
    checks++; if (stall_if !== 1'b0 || fwd_b !== 3'd0) begin
      failures++; $display("FAIL nowrite_load got stall=%b fwd=%0d exp 0/0", stall_if, fwd_b); end
    tick();
  endtask

  task automatic test_div_raw();
    quiet();
    mc_req = 1; rd_id = 5'd7; we_id = 1;
    #1;
    checks++; if (mc_accept !== 1'b1) begin failures++; $display("FAIL div_accept got %b exp 1", mc_accept); end
    tick();
    quiet();
    rs1 = 5'd7;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL div_raw_wait cycle %0d got %b exp 1", i, stall_id); end
      tick();
    end
    mc_done = 1; mc_done_rd = 5'd7;
    #1;
    checks++; if (stall_id !== 1'b0 || fwd_a !== 3'd5) begin
      failures++; $display("FAIL div_done got stall=%b fwd=%0d exp 0/5", stall_id, fwd_a); end
    checks++; if (stall_cycles !== m_scnt()) begin
      failures++; $display("FAIL div_stall_cnt got %0d exp %0d", stall_cycles, m_scnt()); end
    tick();
    mc_done = 0; mc_done_rd = 0;
    #1;
    checks++; if (stall_id !== 1'b0 || fwd_a !== 3'd0) begin
      failures++; $display("FAIL div_after got stall=%b fwd=%0d exp 0/0", stall_id, fwd_a); end
  endtask

  task automatic test_back_to_back();
    quiet();
    mc_req = 1; rd_id = 5'd3; we_id = 1;
    tick();
    rd_id = 5'd4;
    #1;
    checks++; if (stall_if !== 1'b1 || mc_accept !== 1'b0) begin
      failures++; $display("FAIL struct_stall got stall=%b acc=%b exp 1/0", stall_if, mc_accept); end
    tick();
    mc_done = 1; mc_done_rd = 5'd3;
    #1;
    checks++; if (stall_if !== 1'b0 || mc_accept !== 1'b1) begin
      failures++; $display("FAIL b2b_issue got stall=%b acc=%b exp 0/1", stall_if, mc_accept); end
    tick();
    quiet();
    mc_req = 1; rd_id = 5'd8; we_id = 1;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL b2b_busy_kept got %b exp 1", stall_if); end
    quiet();
    rs1 = 5'd3;
    #1;
    checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL b2b_old_cleared got %b exp 0", stall_if); end
    rs1 = 5'd4;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL b2b_new_pending got %b exp 1", stall_if); end
    quiet();
    we_id = 1; rd_id = 5'd4;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL waw_stall got %b exp 1", stall_if); end
    mc_done = 1; mc_done_rd = 5'd4;
    #1;
    checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL waw_bypass got %b exp 0", stall_if); end
    tick();
    quiet();
  endtask

  task automatic test_branch_priority();
    logic [CW-1:0] s0, f0;
    quiet();
    mc_req = 1; rd_id = 5'd10; we_id = 1;
    tick();
    quiet();
    mc_done = 1; mc_done_rd = 5'd31;
    tick();
    quiet();
    s0 = m_scnt(); f0 = m_fcnt();
    rs1 = 5'd10; branch = 1; mc_req = 1; rd_id = 5'd11;
    #1;
    checks++; if ({stall_if, stall_id, flush_id, flush_ex, mc_accept} !== 5'b00110) begin
      failures++; $display("FAIL branch_prio got %b exp 00110", {stall_if, stall_id, flush_id, flush_ex, mc_accept}); end
    tick();
    quiet();
    #1;
`ifdef HAZARD_PERF_EN
    checks++; if (flush_cycles !== f0 + 1 || stall_cycles !== s0) begin
      failures++; $display("FAIL branch_counters got %0d/%0d exp %0d/%0d", flush_cycles, stall_cycles, f0 + 1, s0); end
`else
    checks++; if (flush_cycles !== '0 || stall_cycles !== '0) begin
      failures++; $display("FAIL branch_counters got %0d/%0d exp 0/0", flush_cycles, stall_cycles); end
`endif
    mc_done = 1; mc_done_rd = 5'd10;
    tick();
    quiet();
  endtask

  task automatic test_async_reset_mid_div();
    quiet();
    mc_req = 1; rd_id = 5'd9; we_id = 1;
    tick();
    quiet();
    rs1 = 5'd9;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got %b exp 1", stall_if); end
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    checks++; if (stall_if !== 1'b0 || stall_cycles !== '0 || flush_cycles !== '0) begin
      failures++; $display("FAIL async_reset got stall=%b cnt=%0d/%0d exp 0/0/0", stall_if, stall_cycles, flush_cycles); end
    @(negedge clk);
    rst = 1'b0;
    quiet();
    mc_done = 1; mc_done_rd = 5'd9;
    tick();
    quiet();
    mc_req = 1; rd_id = 5'd12; we_id = 1;
    #1;
    checks++; if (stall_if !== 1'b0 || mc_accept !== 1'b1) begin
      failures++; $display("FAIL late_done_busy got stall=%b acc=%b exp 0/1", stall_if, mc_accept); end
    tick();
    quiet();
    mc_done = 1; mc_done_rd = 5'd12;
    tick();
    quiet();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rs1        = AW'($urandom_range(0, 7));
      rs2        = AW'($urandom_range(0, 7));
      rd_id      = AW'($urandom_range(0, 7));
      rd_ex      = AW'($urandom_range(0, 7));
      rd_mem     = AW'($urandom_range(0, 7));
      we_id      = 1'($urandom_range(0, 1));
      mc_req     = ($urandom_range(0, 2) == 0);
      we_ex      = 1'($urandom_range(0, 1));
      we_mem     = 1'($urandom_range(0, 1));
      we_wb      = 1'($urandom_range(0, 1));
      rd_wb      = we_wb ? AW'($urandom_range(0, 7)) : '0;
      sel_wb_ex  = 2'($urandom_range(0, 3));
      sel_wb_mem = 2'($urandom_range(0, 3));
      branch     = ($urandom_range(0, 7) == 0);
      mc_done    = ($urandom_range(0, 3) == 0);
      mc_done_rd = AW'($urandom_range(0, 7));
      #1;
      checks++; if (fwd_a !== m_fwd(rs1)) begin failures++; $display("FAIL rnd fwd_a cyc %0d got %0d exp %0d", i, fwd_a, m_fwd(rs1)); end
      checks++; if (fwd_b !== m_fwd(rs2)) begin failures++; $display("FAIL rnd fwd_b cyc %0d got %0d exp %0d", i, fwd_b, m_fwd(rs2)); end
      checks++; if (stall_if !== m_stall() || stall_id !== m_stall()) begin
        failures++; $display("FAIL rnd stall cyc %0d got %b/%b exp %b", i, stall_if, stall_id, m_stall()); end
      checks++; if (flush_id !== branch || flush_ex !== (branch | m_stall())) begin
        failures++; $display("FAIL rnd flush cyc %0d got %b/%b exp %b/%b", i, flush_id, flush_ex, branch, branch | m_stall()); end
      checks++; if (mc_accept !== m_accept()) begin
        failures++; $display("FAIL rnd accept cyc %0d got %b exp %b", i, mc_accept, m_accept()); end
      checks++; if (stall_cycles !== m_scnt() || flush_cycles !== m_fcnt()) begin
        failures++; $display("FAIL rnd counters cyc %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, flush_cycles, m_scnt(), m_fcnt()); end
      tick();
    end
    quiet();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    m_reset();
    test_reset();
    test_load_use();
    test_x0_load();
    test_div_raw();
    test_back_to_back();
    test_branch_priority();
    test_async_reset_mid_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
